hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register Tnew scoreboard with mult/div busy tracking.
// Raises ID-stage stalls when a source operand or HI/LO is not yet ready.
module hazard_scoreboard #(
  parameter int REG_W       = 5,
  parameter int T_W         = 2,
  parameter int MD_MULT_CYC = 5,
  parameter int MD_DIV_CYC  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [T_W-1:0]   id_rs_tuse,
  input  logic [T_W-1:0]   id_rt_tuse,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_addr,
  input  logic [T_W-1:0]   id_tnew,
  input  logic             id_md_start,
  input  logic             id_md_is_div,
  input  logic             id_md_use,
  input  logic             flush,
  output logic             stall,
  output logic             stall_rs,
  output logic             stall_rt,
  output logic             stall_md,
  output logic             md_busy,
  output logic [REG_W:0]   pending_cnt
);

  localparam int NREG = 1 << REG_W;
  localparam int MD_W = $clog2(MD_DIV_CYC + 1);

  logic             w_issue;
  logic             w_rs_hz;
  logic             w_rt_hz;
  logic             w_md_hz;
  logic             w_md_ld;
  logic [MD_W-1:0]  w_md_ld_val;
  logic [MD_W-1:0]  r_md;
  logic [T_W-1:0]   w_entry [NREG];
  logic [REG_W:0]   w_pending;

  assign w_issue = id_valid & ~stall & ~flush;

  // $0 never has a pending producer.
  assign w_entry[0] = '0;

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    logic           r_ent;
    logic [T_W-1:0] r_cnt;
    logic           w_ld;

    assign w_ld = w_issue & id_wr_en &
                  (id_wr_addr == REG_W'(g));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (flush) begin
        r_cnt <= '0;
      end else if (w_ld) begin
        r_cnt <= id_tnew;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - T_W'(1);
      end
    end

    assign r_ent      = 1'b0;
    assign w_entry[g] = r_cnt;
  end

  assign w_md_ld     = w_issue & id_md_start;
  assign w_md_ld_val = id_md_is_div ? MD_W'(MD_DIV_CYC)
                                    : MD_W'(MD_MULT_CYC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md <= '0;
    end else if (flush) begin
      r_md <= '0;
    end else if (w_md_ld) begin
      r_md <= w_md_ld_val;
    end else if (r_md != '0) begin
      r_md <= r_md - MD_W'(1);
    end
  end

  assign md_busy = (r_md != '0);

  assign w_rs_hz = id_valid & id_rs_used &
                   (id_rs != '0) &
                   (w_entry[id_rs] > id_rs_tuse);
  assign w_rt_hz = id_valid & id_rt_used &
                   (id_rt != '0) &
                   (w_entry[id_rt] > id_rt_tuse);
  assign w_md_hz = id_valid & id_md_use & md_busy;

  assign stall_rs = w_rs_hz & ~flush;
  assign stall_rt = w_rt_hz & ~flush;
  assign stall_md = w_md_hz & ~flush;
  assign stall    = (stall_rs | stall_rt | stall_md) & ~flush;

  always_comb begin
    w_pending = '0;
    for (int i = 1; i < NREG; i++) begin
      w_pending = w_pending +
                  {{REG_W{1'b0}}, |w_entry[i]};
    end
  end

  assign pending_cnt = w_pending;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Each task drives one scenario and checks its outputs inline.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [1:0] id_rs_tuse;
  logic [1:0] id_rt_tuse;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic [1:0] id_tnew;
  logic       id_md_start;
  logic       id_md_is_div;
  logic       id_md_use;
  logic       flush;
  logic       stall;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;
  logic       md_busy;
  logic [5:0] pending_cnt;

  int n_cmp;
  int n_fail;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rs_tuse   (id_rs_tuse),
    .id_rt_tuse   (id_rt_tuse),
    .id_wr_en     (id_wr_en),
    .id_wr_addr   (id_wr_addr),
    .id_tnew      (id_tnew),
    .id_md_start  (id_md_start),
    .id_md_is_div (id_md_is_div),
    .id_md_use    (id_md_use),
    .flush        (flush),
    .stall        (stall),
    .stall_rs     (stall_rs),
    .stall_rt     (stall_rt),
    .stall_md     (stall_md),
    .md_busy      (md_busy),
    .pending_cnt  (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_valid     = 0;
    id_rs        = 0;
    id_rt        = 0;
    id_rs_used   = 0;
    id_rt_used   = 0;
    id_rs_tuse   = 0;
    id_rt_tuse   = 0;
    id_wr_en     = 0;
    id_wr_addr   = 0;
    id_tnew      = 0;
    id_md_start  = 0;
    id_md_is_div = 0;
    id_md_use    = 0;
    flush        = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic producer(input logic [4:0] a,
                          input logic [1:0] t);
    idle();
    id_valid   = 1;
    id_wr_en   = 1;
    id_wr_addr = a;
    id_tnew    = t;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (stall !== 0 || md_busy !== 0 ||
        pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset: stall=%b busy=%b cnt=%0d want 0 0 0",
               stall, md_busy, pending_cnt);
    end
  endtask

  task automatic test_load_use();
    producer(5'd8, 2'd2);
    #1;
    n_cmp++;
    if (stall !== 0) begin
      n_fail++;
      $display("FAIL lu_prod: stall=%b want 0", stall);
    end
    tick();
    idle();
    id_valid = 1; id_rs = 8; id_rs_used = 1; id_rs_tuse = 1;
    #1;
    n_cmp++;
    if (stall !== 1 || stall_rs !== 1 || pending_cnt !== 1) begin
      n_fail++;
      $display("FAIL lu_c1: stall=%b rs=%b cnt=%0d want 1 1 1",
               stall, stall_rs, pending_cnt);
    end
    tick();
    n_cmp++;
    if (stall !== 0 || pending_cnt !== 1) begin
      n_fail++;
      $display("FAIL lu_c2: stall=%b cnt=%0d want 0 1",
               stall, pending_cnt);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL lu_c3: cnt=%0d want 0", pending_cnt);
    end
  endtask

  task automatic test_branch();
    producer(5'd9, 2'd1);
    tick();
    idle();
    id_valid = 1; id_rt = 9; id_rt_used = 1; id_rt_tuse = 0;
    #1;
    n_cmp++;
    if (stall_rt !== 1 || stall !== 1 || stall_rs !== 0) begin
      n_fail++;
      $display("FAIL br_t0: rt=%b stall=%b rs=%b want 1 1 0",
               stall_rt, stall, stall_rs);
    end
    tick();
    n_cmp++;
    if (stall_rt !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL br_t0_next: rt=%b stall=%b want 0 0",
               stall_rt, stall);
    end
    producer(5'd9, 2'd1);
    tick();
    idle();
    id_valid = 1; id_rt = 9; id_rt_used = 1; id_rt_tuse = 1;
    #1;
    n_cmp++;
    if (stall !== 0 || pending_cnt !== 1) begin
      n_fail++;
      $display("FAIL br_t1: stall=%b cnt=%0d want 0 1",
               stall, pending_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_zero_link();
    producer(5'd0, 2'd2);
    tick();
    idle();
    id_valid = 1;
    id_rs = 0; id_rs_used = 1; id_rs_tuse = 0;
    id_rt = 0; id_rt_used = 1; id_rt_tuse = 0;
    #1;
    n_cmp++;
    if (pending_cnt !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL zero: cnt=%0d stall=%b want 0 0",
               pending_cnt, stall);
    end
    tick();
    producer(5'd31, 2'd0);
    tick();
    idle();
    id_valid = 1; id_rs = 31; id_rs_used = 1; id_rs_tuse = 0;
    #1;
    n_cmp++;
    if (stall !== 0 || pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL link: stall=%b cnt=%0d want 0 0",
               stall, pending_cnt);
    end
    tick();
    idle();
  endtask

  task automatic test_muldiv();
    int busy;
    idle();
    id_valid = 1; id_md_start = 1; id_md_is_div = 1;
    tick();
    idle();
    id_valid = 1; id_md_use = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if (md_busy !== 1 || stall_md !== 1 || stall !== 1) begin
        n_fail++;
        $display("FAIL div_c%0d: busy=%b smd=%b want 1 1",
                 i, md_busy, stall_md);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (md_busy !== 0 || stall_md !== 0 || stall !== 0) begin
      n_fail++;
      $display("FAIL div_end: busy=%b smd=%b want 0 0",
               md_busy, stall_md);
    end
    tick();
    idle();
    id_valid = 1; id_md_start = 1; id_md_is_div = 0;
    tick();
    idle();
    busy = 0;
    for (int i = 0; i < 20 && md_busy === 1; i++) begin
      busy++;
      tick();
    end
    n_cmp++;
    if (busy !== 5) begin
      n_fail++;
      $display("FAIL mult_len: cycles=%0d want 5", busy);
    end
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1; id_md_start = 1;
    tick();
    producer(5'd8, 2'd2);
    tick();
    idle();
    id_valid = 1; id_rs = 8; id_rs_used = 1; id_rs_tuse = 0;
    id_md_use = 1;
    #1;
    n_cmp++;
    if (stall !== 1 || stall_rs !== 1 || stall_md !== 1) begin
      n_fail++;
      $display("FAIL fl_pre: stall=%b rs=%b md=%b want 1 1 1",
               stall, stall_rs, stall_md);
    end
    flush = 1;
    #1;
    n_cmp++;
    if (stall !== 0 || stall_rs !== 0 || stall_md !== 0 ||
        pending_cnt !== 1 || md_busy !== 1) begin
      n_fail++;
      $display("FAIL fl_now: st=%b rs=%b md=%b cnt=%0d busy=%b want 0 0 0 1 1",
               stall, stall_rs, stall_md, pending_cnt, md_busy);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (pending_cnt !== 0 || md_busy !== 0) begin
      n_fail++;
      $display("FAIL fl_after: cnt=%0d busy=%b want 0 0",
               pending_cnt, md_busy);
    end
  endtask

  task automatic test_reset_midop();
    producer(5'd5, 2'd3);
    id_md_start = 1; id_md_is_div = 1;
    tick();
    producer(5'd6, 2'd3);
    tick();
    producer(5'd7, 2'd3);
    tick();
    idle();
    id_valid = 1; id_rs = 7; id_rs_used = 1; id_rs_tuse = 0;
    id_md_use = 1;
    #1;
    n_cmp++;
    if (pending_cnt !== 3 || md_busy !== 1 || stall !== 1) begin
      n_fail++;
      $display("FAIL rm_pre: cnt=%0d busy=%b stall=%b want 3 1 1",
               pending_cnt, md_busy, stall);
    end
    reset = 0;
    #1;
    n_cmp++;
    if (stall !== 0 || stall_rs !== 0 || stall_rt !== 0 ||
        stall_md !== 0 || md_busy !== 0 || pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL rm_low: st=%b busy=%b cnt=%0d want 0 0 0",
               stall, md_busy, pending_cnt);
    end
    #1;
    reset = 1;
    #1;
    n_cmp++;
    if (stall !== 0 || md_busy !== 0 || pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL rm_rel: st=%b busy=%b cnt=%0d want 0 0 0",
               stall, md_busy, pending_cnt);
    end
    tick();
    n_cmp++;
    if (stall !== 0 || md_busy !== 0 || pending_cnt !== 0) begin
      n_fail++;
      $display("FAIL rm_edge: st=%b busy=%b cnt=%0d want 0 0 0",
               stall, md_busy, pending_cnt);
    end
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 0;
    idle();
    #12;
    test_reset();
    reset = 1;
    tick();
    test_load_use();
    test_branch();
    test_zero_link();
    test_muldiv();
    test_flush();
    test_reset_midop();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
